// File: rtl/i2s_transmit.sv
// I2S transmitter: a PCM sample FIFO feeding a mono, MSB-first I2S serializer.
// The bit clock is divided down from clk; one sample is popped per 64-slot frame.
module i2s_transmit #(
   parameter int DATA_IN_SIZE  = 16,
   parameter int I2S_DATA_SIZE = 24,
   parameter int CLK_FREQ      = 100_000_000,
   parameter int I2S_CLK_FREQ  = 1_500_000,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_IN_SIZE-1:0]     pcm_in,
   input  logic                        pcm_valid,
   output logic                        pcm_ready,
   output logic                        i2s_clk,
   output logic                        i2s_ws,
   output logic                        i2s_sd,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int HALF_DIV = CLK_FREQ / (2 * I2S_CLK_FREQ);
   localparam int CW       = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);

   if (HALF_DIV < 2) begin : g_bad_div
      $error("i2s_transmit: HALF_DIV must be at least 2");
   end
   if (DATA_IN_SIZE > I2S_DATA_SIZE) begin : g_bad_width
      $error("i2s_transmit: DATA_IN_SIZE exceeds I2S_DATA_SIZE");
   end
   if (I2S_DATA_SIZE > 31) begin : g_bad_slot
      $error("i2s_transmit: I2S_DATA_SIZE exceeds 31");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("i2s_transmit: FIFO_DEPTH must be a power of 2");
   end

   logic [CW-1:0]           div_q, div_d;
   logic                    sclk_q, sclk_d;
   logic [5:0]              slot_q, slot_d;
   logic                    ws_q, ws_d;
   logic                    sd_q, sd_d;
   logic                    und_q, und_d;
   logic [DATA_IN_SIZE-1:0] word_q, word_d;
   logic [AW-1:0]           wr_q, wr_d;
   logic [AW-1:0]           rd_q, rd_d;
   logic [AW:0]             lvl_q, lvl_d;
   logic [DATA_IN_SIZE-1:0] mem_q [FIFO_DEPTH];

   logic                    tick;
   logic                    fall;
   logic                    pop;
   logic                    push;
   logic                    empty;
   logic [5:0]              slot_n;
   logic [4:0]              j;
   logic [31:0]             word_ext;

   assign tick      = (div_q == CW'(HALF_DIV - 1));
   assign fall      = tick & sclk_q;
   assign slot_n    = slot_q + 6'd1;
   assign j         = slot_n[4:0];
   assign empty     = (lvl_q == '0);
   assign pop       = fall & (slot_q == 6'd63);
   assign pcm_ready = (lvl_q != (AW + 1)'(FIFO_DEPTH));
   assign push      = pcm_valid & pcm_ready;

   // Sample MSB sits at bit 31, so slot j reads bit 32-j; pad bits are zero.
   assign word_ext  = 32'(word_q) << (32 - DATA_IN_SIZE);

   always_comb begin
      div_d  = tick ? '0 : div_q + CW'(1);
      sclk_d = sclk_q ^ tick;
      slot_d = slot_q;
      ws_d   = ws_q;
      sd_d   = sd_q;
      word_d = word_q;
      und_d  = 1'b0;
      rd_d   = rd_q;
      wr_d   = wr_q;
      lvl_d  = lvl_q;
      if (fall) begin
         slot_d = slot_n;
         ws_d   = slot_n[5];
         sd_d   = (j != 5'd0) & word_ext[5'd0 - j];
      end
      if (pop) begin
         if (empty) begin
            word_d = '0;
            und_d  = 1'b1;
         end else begin
            word_d = mem_q[rd_q];
            rd_d   = rd_q + AW'(1);
         end
      end
      if (push) begin
         wr_d = wr_q + AW'(1);
      end
      case ({push, pop & ~empty})
         2'b10:   lvl_d = lvl_q + (AW + 1)'(1);
         2'b01:   lvl_d = lvl_q - (AW + 1)'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= 1'b0;
         slot_q <= '0;
         ws_q   <= 1'b0;
         sd_q   <= 1'b0;
         und_q  <= 1'b0;
         word_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         lvl_q  <= '0;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
         slot_q <= slot_d;
         ws_q   <= ws_d;
         sd_q   <= sd_d;
         und_q  <= und_d;
         word_q <= word_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         lvl_q  <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q] <= pcm_in;
      end
   end

   assign i2s_clk    = sclk_q;
   assign i2s_ws     = ws_q;
   assign i2s_sd     = sd_q;
   assign underrun   = und_q;
   assign fifo_level = lvl_q;

endmodule

// File: tb/tb_i2s_transmit.sv
// Bench for i2s_transmit: table-driven FIFO fill, hand-written frame sequences
// and random pushes, all checked against a time-based behavioural model.
module tb_i2s_transmit;

   localparam int HD = 33;
   localparam int BP = 2 * HD;
   localparam int FR = 64 * BP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pcm_in = '0;
   logic        pcm_valid = 1'b0;
   logic        pcm_ready;
   logic        i2s_clk;
   logic        i2s_ws;
   logic        i2s_sd;
   logic        underrun;
   logic [4:0]  fifo_level;

   i2s_transmit dut (
      .clk        (clk),
      .rst        (rst),
      .pcm_in     (pcm_in),
      .pcm_valid  (pcm_valid),
      .pcm_ready  (pcm_ready),
      .i2s_clk    (i2s_clk),
      .i2s_ws     (i2s_ws),
      .i2s_sd     (i2s_sd),
      .underrun   (underrun),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic [15:0] d;
      logic [4:0]  lvl;
      bit          rdy;
   } vec_t;

   vec_t        tbl [18];
   int          checks = 0;
   int          passed = 0;
   int          t = 0;
   logic [15:0] q [$];
   logic [15:0] word = '0;
   bit          und = 1'b0;
   logic [63:0] cap = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
   endtask

   function automatic logic [63:0] fexp(input logic [15:0] s);
      logic [31:0] h;
      h = {1'b0, s, 8'h00, 7'h00};
      return {h, h};
   endfunction

   task automatic check_model();
      int          f;
      int          k;
      int          j;
      logic [23:0] w;
      bit          sclk;
      bit          ws;
      bit          sd;
      f    = t / BP;
      k    = f % 64;
      j    = k % 32;
      w    = {word, 8'h00};
      sclk = ((t / HD) % 2) == 1;
      ws   = k >= 32;
      sd   = (j >= 1 && j <= 24) ? w[24-j] : 1'b0;
      chk("outputs", {i2s_clk, i2s_ws, i2s_sd, underrun, pcm_ready, fifo_level},
          {sclk, ws, sd, und, q.size() != 16, 5'(q.size())});
   endtask

   task automatic step(input bit r, input bit v, input logic [15:0] d);
      bit pushok;
      rst       = r;
      pcm_valid = v;
      pcm_in    = d;
      pushok    = v && q.size() < 16;
      @(posedge clk);
      if (r) begin
         t    = 0;
         q.delete();
         word = '0;
         und  = 1'b0;
      end else begin
         t++;
         und = 1'b0;
         if (t % FR == 0) begin
            if (q.size() == 0) begin
               und  = 1'b1;
               word = '0;
            end else begin
               word = q.pop_front();
            end
         end
         if (pushok) q.push_back(d);
      end
      #1;
      check_model();
      if (!r) begin
         if (t % BP == 0) cap[63 - ((t / BP) % 64)] = i2s_sd;
         if (t == HD - 1 || t == BP) chk("sclk_low", i2s_clk, 0);
         if (t == HD || t == BP + HD) chk("sclk_high", i2s_clk, 1);
         if (t == 32 * BP - 1) chk("ws_left", i2s_ws, 0);
         if (t == 32 * BP) chk("ws_right", i2s_ws, 1);
      end
   endtask

   task automatic run_to(input int tend, input int rate);
      bit v;
      while (t < tend) begin
         v = (rate != 0) && ($urandom_range(rate - 1) == 0);
         step(1'b0, v, 16'($urandom));
      end
   endtask

   initial begin
      logic [15:0] s0;
      logic [15:0] s1;
      logic        sd_any;

      tbl[0] = '{1'b1, 16'hA5A5, 5'd1, 1'b1};
      for (int i = 1; i < 16; i++) tbl[i] = '{1'b1, 16'($urandom), 5'(i + 1), (i + 1) != 16};
      tbl[16] = '{1'b1, 16'hDEAD, 5'd16, 1'b0};
      tbl[17] = '{1'b0, 16'h0000, 5'd16, 1'b0};
      s0 = 16'h8001;
      s1 = 16'h3C5A;

      repeat (3) step(1'b1, 1'b0, '0);
      chk("reset_state", {i2s_clk, i2s_ws, i2s_sd, underrun, pcm_ready, fifo_level}, 10'h020);

      // empty FIFO at first pop, coincident with a push
      run_to(FR - 1, 0);
      step(1'b0, 1'b1, s0);
      chk("underrun_pulse", underrun, 1);
      chk("level_after_empty_pop", fifo_level, 1);
      step(1'b0, 1'b0, '0);
      chk("underrun_one_clk", underrun, 0);
      sd_any = 1'b0;
      while (t < 2 * FR - 1) begin
         step(1'b0, 1'b0, '0);
         sd_any = sd_any | i2s_sd;
      end
      chk("underrun_frame_sd", sd_any, 0);
      chk("frame1_zero", cap, 64'h0);

      // level 1, push coincident with pop
      step(1'b0, 1'b1, s1);
      chk("level_coincident", fifo_level, 1);
      chk("no_underrun", underrun, 0);
      run_to(3 * FR - 1, 0);
      chk("frame2_s0", cap, fexp(s0));

      // queue 5 samples, then reset at slot 40
      run_to(3 * FR, 0);
      for (int i = 0; i < 5; i++) begin
         run_to(3 * FR + 200 * (i + 1) - 1, 0);
         step(1'b0, 1'b1, 16'($urandom));
      end
      run_to(3 * FR + 40 * BP + 5, 0);
      chk("level_before_reset", fifo_level, 5);
      chk("frame3_left_s1", cap[63:32], {1'b0, s1, 8'h00, 7'h00});
      step(1'b1, 1'b0, '0);
      chk("midframe_reset", {i2s_clk, i2s_ws, i2s_sd, underrun, pcm_ready, fifo_level}, 10'h020);

      // table-driven fill past full
      for (int i = 0; i < 18; i++) begin
         step(1'b0, tbl[i].v, tbl[i].d);
         chk($sformatf("fill_level_%0d", i), fifo_level, tbl[i].lvl);
         chk($sformatf("fill_ready_%0d", i), pcm_ready, tbl[i].rdy);
      end

      run_to(FR, 0);
      chk("level_after_pop", fifo_level, 15);
      run_to(2 * FR - 1, 300);
      chk("frame1_a5a5", cap, 64'h52D28000_52D28000);
      run_to(3 * FR - 1, 300);
      chk("frame2_order", cap, fexp(tbl[1].d));
      run_to(4 * FR - 1, 300);
      chk("frame3_order", cap, fexp(tbl[2].d));
      run_to(6 * FR, 300);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
